// File: rtl/cache_axi_bridge.sv
// Cache refill/writeback/uncached request bridge onto AXI4 master channels.
// Optional BRIDGE_RAW_ADDR_CHECK_EN: reads only wait on writes to the same line.
module cache_axi_bridge #(
  parameter int unsigned ID_W       = 4,
  parameter int unsigned RD_ID      = 0,
  parameter int unsigned WR_ID      = 1,
  parameter int unsigned LINE_BEATS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rd_req,
  input  logic [2:0]      rd_type,
  input  logic [31:0]     rd_addr,
  output logic            rd_rdy,
  output logic            ret_valid,
  output logic            ret_last,
  output logic [31:0]     ret_data,
  input  logic            wr_req,
  input  logic [2:0]      wr_type,
  input  logic [31:0]     wr_addr,
  input  logic [3:0]      wr_wstrb,
  input  logic [127:0]    wr_data,
  output logic            wr_rdy,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic            awvalid,
  input  logic            awready,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready,
  output logic            bus_err
);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_AR   = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_SEND = 2'd1;
  localparam logic [1:0] W_B    = 2'd2;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] LAST_BEAT  = 2'(LINE_BEATS - 1);

  logic [1:0]   r_state, r_next;
  logic [2:0]   r_type;
  logic [31:0]  r_addr;
  logic [1:0]   r_beat;
  logic [1:0]   w_state, w_next;
  logic [2:0]   w_type;
  logic [31:0]  w_addr;
  logic [3:0]   w_strb;
  logic [127:0] w_buf;
  logic [1:0]   w_beat;
  logic         aw_done, w_done;

  logic rd_block, rd_accept, r_hs, rd_line, exp_last;
  logic wr_accept, wr_line, aw_hs, w_hs, aw_fin, w_fin;
  logic [1:0] wd_sel;
  logic unused_ok;

  assign unused_ok = ^{rid, bid};

  // Read ordering against the write path
`ifdef BRIDGE_RAW_ADDR_CHECK_EN
  assign rd_block = ((w_state != W_IDLE) && (rd_addr[31:4] == w_addr[31:4])) ||
                    (wr_req && (w_state == W_IDLE) && (rd_addr[31:4] == wr_addr[31:4]));
`else
  assign rd_block = (w_state != W_IDLE) || wr_req;
`endif

  // Read path
  assign rd_rdy    = !reset && (r_state == R_IDLE) && !rd_block;
  assign rd_accept = rd_req && rd_rdy;
  assign rd_line   = r_type[2];
  assign rready    = (r_state == R_DATA);
  assign r_hs      = rready && rvalid;
  assign exp_last  = (r_beat == (rd_line ? LAST_BEAT : 2'd0));

  assign arid      = ID_W'(RD_ID);
  assign arvalid   = (r_state == R_AR);
  assign araddr    = rd_line ? {r_addr[31:4], 4'h0} : r_addr;
  assign arlen     = rd_line ? 8'(LAST_BEAT) : 8'd0;
  assign arsize    = rd_line ? 3'd2 : {1'b0, r_type[1:0]};
  assign arburst   = BURST_INCR;

  assign ret_valid = r_hs;
  assign ret_last  = rready && rlast;
  assign ret_data  = rdata;

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (rd_accept) r_next = R_AR;
      R_AR:    if (arready) r_next = R_DATA;
      R_DATA:  if (rvalid && rlast) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      r_type  <= 3'd0;
      r_addr  <= 32'd0;
      r_beat  <= 2'd0;
    end else begin
      r_state <= r_next;
      if (rd_accept) begin
        r_type <= rd_type;
        r_addr <= rd_addr;
        r_beat <= 2'd0;
      end else if (r_hs) begin
        r_beat <= r_beat + 2'd1;
      end
    end
  end

  // Write path: AW and W retire independently, B waits for both
  assign wr_rdy    = !reset && (w_state == W_IDLE);
  assign wr_accept = wr_req && wr_rdy;
  assign wr_line   = w_type[2];
  assign awvalid   = (w_state == W_SEND) && !aw_done;
  assign wvalid    = (w_state == W_SEND) && !w_done;
  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign wlast     = wvalid && (wr_line ? (w_beat == LAST_BEAT) : 1'b1);
  assign aw_fin    = aw_done || aw_hs;
  assign w_fin     = w_done || (w_hs && wlast);
  assign bready    = (w_state == W_B);

  assign awid      = ID_W'(WR_ID);
  assign awaddr    = wr_line ? {w_addr[31:4], 4'h0} : w_addr;
  assign awlen     = wr_line ? 8'(LAST_BEAT) : 8'd0;
  assign awsize    = wr_line ? 3'd2 : {1'b0, w_type[1:0]};
  assign awburst   = BURST_INCR;
  assign wd_sel    = wr_line ? w_beat : w_addr[3:2];
  assign wdata     = w_buf[{wd_sel, 5'b0} +: 32];
  assign wstrb     = wr_line ? 4'hf : w_strb;

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (wr_accept) w_next = W_SEND;
      W_SEND:  if (aw_fin && w_fin) w_next = W_B;
      W_B:     if (bvalid) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      w_type  <= 3'd0;
      w_addr  <= 32'd0;
      w_strb  <= 4'd0;
      w_buf   <= 128'd0;
      w_beat  <= 2'd0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_next;
      if (wr_accept) begin
        w_type  <= wr_type;
        w_addr  <= wr_addr;
        w_strb  <= wr_wstrb;
        w_buf   <= wr_data;
        w_beat  <= 2'd0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs) begin
          w_beat <= w_beat + 2'd1;
          if (wlast) w_done <= 1'b1;
        end
      end
    end
  end

  // Error responses and burst-length disagreements share one pulse
  always_ff @(posedge clk) begin
    if (reset) bus_err <= 1'b0;
    else bus_err <= (r_hs && ((rresp != RESP_OKAY) || (rlast != exp_last))) ||
                    (bvalid && bready && (bresp != RESP_OKAY));
  end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed + randomized bench for cache_axi_bridge with a transaction-level slave model.
module tb_cache_axi_bridge;
  localparam int unsigned ID_W = 4;

  logic clk = 1'b0;
  logic reset;
  logic rd_req; logic [2:0] rd_type; logic [31:0] rd_addr; logic rd_rdy;
  logic ret_valid, ret_last; logic [31:0] ret_data;
  logic wr_req; logic [2:0] wr_type; logic [31:0] wr_addr; logic [3:0] wr_wstrb;
  logic [127:0] wr_data; logic wr_rdy;
  logic [ID_W-1:0] arid; logic [31:0] araddr; logic [7:0] arlen; logic [2:0] arsize;
  logic [1:0] arburst; logic arvalid, arready;
  logic [ID_W-1:0] rid; logic [31:0] rdata; logic [1:0] rresp; logic rlast, rvalid, rready;
  logic [ID_W-1:0] awid; logic [31:0] awaddr; logic [7:0] awlen; logic [2:0] awsize;
  logic [1:0] awburst; logic awvalid, awready;
  logic [31:0] wdata; logic [3:0] wstrb; logic wlast, wvalid, wready;
  logic [ID_W-1:0] bid; logic [1:0] bresp; logic bvalid, bready;
  logic bus_err;

  int total = 0, passed = 0, fails = 0, err_cnt = 0;

  cache_axi_bridge dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus_err === 1'b1) err_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [2:0] t, input logic [31:0] a, input int err_beat,
                         input int ar_dly, input int exp_err);
    int n, e0, gap;
    logic [31:0] d;
    n  = t[2] ? 4 : 1;
    e0 = err_cnt;
    @(negedge clk);
    rd_req = 1'b1; rd_type = t; rd_addr = a;
    #1 chk("rd_rdy_accept", rd_rdy, 1'b1);
    @(negedge clk);
    rd_req = 1'b0; rd_addr = $urandom;
    #1;
    chk("rd_rdy_busy", rd_rdy, 1'b0);
    chk("arvalid", arvalid, 1'b1);
    chk("araddr", araddr, t[2] ? {a[31:4], 4'h0} : a);
    chk("arlen", arlen, t[2] ? 8'd3 : 8'd0);
    chk("arsize", arsize, t[2] ? 3'd2 : {1'b0, t[1:0]});
    chk("arburst", arburst, 2'b01);
    chk("arid", arid, 4'd0);
    repeat (ar_dly) begin
      @(negedge clk); #1;
      chk("arvalid_hold", arvalid, 1'b1);
      chk("araddr_hold", araddr, t[2] ? {a[31:4], 4'h0} : a);
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    #1;
    chk("arvalid_drop", arvalid, 1'b0);
    chk("rready", rready, 1'b1);
    for (int k = 0; k < n; k++) begin
      gap = int'($urandom_range(0, 2));
      repeat (gap) begin
        @(negedge clk); #1;
        chk("ret_valid_idle", ret_valid, 1'b0);
      end
      d = $urandom;
      rvalid = 1'b1; rdata = d; rlast = (k == n - 1); rid = 4'd0;
      rresp = (k == err_beat) ? 2'b10 : 2'b00;
      #1;
      chk("ret_valid", ret_valid, 1'b1);
      chk("ret_data", ret_data, d);
      chk("ret_last", ret_last, (k == n - 1));
      @(negedge clk);
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      #1;
    end
    chk("rd_rdy_after", rd_rdy, 1'b1);
    chk("rready_after", rready, 1'b0);
    chk("rd_err_count", err_cnt - e0, exp_err);
  endtask

  task automatic do_write(input logic [2:0] t, input logic [31:0] a, input logic [3:0] strb,
                          input logic [127:0] data, input bit aw_late, input logic [1:0] br,
                          input int exp_err);
    int nb, beat, since_w, e0, gap;
    bit awd, wd;
    logic ar_r, wr_r;
    nb = t[2] ? 4 : 1;
    beat = 0; since_w = 0; awd = 0; wd = 0;
    e0 = err_cnt;
    @(negedge clk);
    wr_req = 1'b1; wr_type = t; wr_addr = a; wr_wstrb = strb; wr_data = data;
    #1 chk("wr_rdy_accept", wr_rdy, 1'b1);
    @(negedge clk);
    wr_req = 1'b0; wr_data = {$urandom, $urandom, $urandom, $urandom};
    #1 chk("wr_rdy_busy", wr_rdy, 1'b0);
    for (int c = 0; c < 60 && !(awd && wd); c++) begin
      ar_r = aw_late ? (wd && since_w >= 3) : 1'($urandom_range(0, 1));
      wr_r = aw_late ? 1'b1 : 1'($urandom_range(0, 1));
      awready = ar_r; wready = wr_r;
      chk("no_early_b", bready, 1'b0);
      chk("awvalid", awvalid, !awd);
      if (!awd) begin
        chk("awaddr", awaddr, t[2] ? {a[31:4], 4'h0} : a);
        chk("awlen", awlen, t[2] ? 8'd3 : 8'd0);
        chk("awid", awid, 4'd1);
      end
      chk("wvalid", wvalid, !wd);
      if (!wd) begin
        chk("wdata", wdata, t[2] ? data[32*beat +: 32] : data[32*int'(a[3:2]) +: 32]);
        chk("wstrb", wstrb, t[2] ? 4'hf : strb);
        chk("wlast", wlast, (beat == nb - 1));
      end
      if (!awd && ar_r) awd = 1;
      if (wd) since_w++;
      else if (wr_r) begin
        beat++;
        if (beat == nb) wd = 1;
      end
      @(negedge clk); #1;
    end
    awready = 1'b0; wready = 1'b0;
    chk("wr_send_done", awd && wd, 1'b1);
    chk("bready", bready, 1'b1);
    chk("wvalid_b", wvalid, 1'b0);
    gap = int'($urandom_range(0, 2));
    repeat (gap) begin
      @(negedge clk); #1;
      chk("wr_rdy_wait_b", wr_rdy, 1'b0);
    end
    bvalid = 1'b1; bresp = br; bid = 4'd1;
    #1 chk("wr_rdy_in_b", wr_rdy, 1'b0);
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'b00;
    #1;
    chk("wr_rdy_after", wr_rdy, 1'b1);
    chk("wr_err_count", err_cnt - e0, exp_err);
  endtask

  task automatic probe_rd(input string tag, input logic [31:0] a, input logic exp);
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = a;
    #1 chk(tag, rd_rdy, exp);
    #1 rd_req = 1'b0;
  endtask

  initial begin
    logic [127:0] d;
    logic [2:0] t;
    logic [31:0] a;
    logic diff_exp;
`ifdef BRIDGE_RAW_ADDR_CHECK_EN
    diff_exp = 1'b1;
`else
    diff_exp = 1'b0;
`endif
    reset = 1'b1;
    rd_req = 0; rd_type = 0; rd_addr = 0; wr_req = 0; wr_type = 0; wr_addr = 0;
    wr_wstrb = 0; wr_data = 0; arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
    rvalid = 0; awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rd_rdy", rd_rdy, 1'b0);
    chk("rst_wr_rdy", wr_rdy, 1'b0);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_wlast", wlast, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_bready", bready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_rd_rdy", rd_rdy, 1'b1);
    chk("post_rst_wr_rdy", wr_rdy, 1'b1);

    // Line refill
    do_read(3'b100, 32'h1C00_0014, -1, 1, 0);

    // Uncached word write
    d = {$urandom, $urandom, $urandom, $urandom};
    d[95:64] = 32'h1234_5678;
    do_write(3'b010, 32'hBFAF_8008, 4'b0011, d, 1'b0, 2'b00, 0);

    // Writeback with AW well after the W beats
    do_write(3'b100, 32'h0040_1230, 4'h0, {$urandom, $urandom, $urandom, $urandom},
             1'b1, 2'b00, 0);

    // Read against an in-flight write
    @(negedge clk);
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h8000_0040; wr_data = 128'd0;
    probe_rd("rd_vs_incoming_diff", 32'h8000_1000, diff_exp);
    @(negedge clk);
    wr_req = 1'b0;
    probe_rd("rd_vs_pending_diff", 32'h8000_1000, diff_exp);
    probe_rd("rd_vs_pending_same", 32'h8000_004C, 1'b0);
    awready = 1'b1; wready = 1'b1;
    repeat (4) @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    #1 chk("probe_bready", bready, 1'b1);
    probe_rd("rd_in_b_same", 32'h8000_0044, 1'b0);
    bvalid = 1'b1;
    @(negedge clk);
    bvalid = 1'b0;
    probe_rd("rd_after_b", 32'h8000_0044, 1'b1);

    // Error responses
    do_read(3'b100, 32'h2000_0100, 2, 0, 1);
    do_write(3'b010, 32'h2000_0204, 4'b1111, {$urandom, $urandom, $urandom, $urandom},
             1'b0, 2'b11, 1);

    // Randomized traffic
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0: t = 3'b000;
        1: t = 3'b001;
        2: t = 3'b010;
        default: t = 3'b100;
      endcase
      a = $urandom;
      if (t == 3'b001) a[0] = 1'b0;
      if (t == 3'b010) a[1:0] = 2'b00;
      do_read(t, a, -1, int'($urandom_range(0, 2)), 0);
      t = ($urandom_range(0, 1) == 0) ? 3'b100 : 3'b010;
      a = $urandom;
      a[1:0] = 2'b00;
      do_write(t, a, 4'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'b0, 2'b00, 0);
    end

    // Reset in the middle of a refill
    @(negedge clk);
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h3000_0020;
    @(negedge clk);
    rd_req = 1'b0; arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    repeat (2) begin
      rvalid = 1'b1; rdata = $urandom; rlast = 1'b0;
      @(negedge clk);
    end
    reset = 1'b1;
    #1 chk("mid_rst_rd_rdy", rd_rdy, 1'b0);
    @(negedge clk);
    #1;
    chk("mid_rst_arvalid", arvalid, 1'b0);
    chk("mid_rst_rready", rready, 1'b0);
    chk("mid_rst_ret_valid", ret_valid, 1'b0);
    rvalid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1 chk("mid_rst_rd_rdy_after", rd_rdy, 1'b1);
    do_read(3'b010, 32'h3000_0024, -1, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
